alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX boundary block that drives the ALU's SrcA, SrcB and Operation inputs.
- Decodes RV32I opcode/funct3/funct7 into the 4-bit ALU operation code and selects the operands.
- Registers the result behind a valid/ready handshake with flush support.
- Contains a halt state machine that stops issue after a HALT instruction leaves the stage.

Parameters:
DATA_WIDTH, 32, operand/PC/immediate width
OPCODE_LENGTH, 4, width of Operation output

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  decoded instruction fields valid
in_ready  output  1  stage can accept this cycle
Opcode  input  7  instruction[6:0]
Funct3  input  3  instruction[14:12]
Funct7  input  7  instruction[31:25]
RD1  input  DATA_WIDTH  rs1 read data
RD2  input  DATA_WIDTH  rs2 read data
Imm  input  DATA_WIDTH  sign-extended immediate (pre-formatted by immediate generator)
PC  input  DATA_WIDTH  instruction address
flush  input  1  kill registered and incoming instruction
out_valid  output  1  SrcA/SrcB/Operation hold a live instruction
out_ready  input  1  EX stage consumes this cycle
SrcA  output  DATA_WIDTH  ALU operand A
SrcB  output  DATA_WIDTH  ALU operand B
Operation  output  OPCODE_LENGTH  ALU operation code
illegal  output  1  registered instruction had no valid encoding
halted  output  1  core halted

Behaviour:
- Reset (sync, active-high) sets:
  - out_valid=0, SrcA=0, SrcB=0, Operation=4'b0000, illegal=0, halted=0.
  - State=RUN.
  - Reset overrides flush and handshake.
- Latency: 1 cycle. A load occurs when in_valid && in_ready && !flush. The decoded outputs are visible on the next cycle with out_valid=1.
- in_ready = (state==RUN) && (!out_valid || out_ready). This is combinational and allows full throughput (back-to-back accepts when out_ready=1).
- Output register update, in priority order:
  1. flush: out_valid<=0 and the incoming instruction is dropped.
  2. Load: all outputs are written.
  3. out_ready && out_valid: out_valid<=0.
  4. Otherwise hold.
  - Data outputs keep their last value when out_valid=0.
- Decode, Opcode -> Operation and operands (operands are RD1/RD2 unless noted):
  - R-type 0110011:
    - f3 000: f7 0000000 -> 0010 ADD; f7 0100000 -> 0110 SUB.
    - f3 111 -> 0000. f3 110 -> 0001. f3 100 -> 0011. f3 010 -> 1100. f3 001 -> 0100.
    - f3 101: f7 0000000 -> 0101; f7 0100000 -> 0111.
    - f7 must be 0000000 except for SUB and SRA; any other f7 is illegal. f3 011 is illegal.
  - I-ALU 0010011: SrcB=Imm.
    - f3 000 -> 0010. f3 010 -> 1100. f3 111 -> 0000. f3 110 -> 0001. f3 100 -> 0011.
    - f3 001 with f7=0000000 -> 0100.
    - f3 101: f7 0000000 -> 0101; f7 0100000 -> 0111.
    - f3 011 is illegal; any other f7 on shifts is illegal.
  - Load 0000011, store 0100011: 0010, SrcA=RD1, SrcB=Imm, any Funct3.
  - Branch 1100011: f3 000 -> 1000, 001 -> 1001, 100 -> 1100, 101 -> 1010. Other f3 values are illegal.
  - JAL 1101111: 1101, SrcA=PC, SrcB=Imm.
  - JALR 1100111: 0010, SrcA=RD1, SrcB=Imm.
  - LUI 0110111: 0010, SrcA=0, SrcB=Imm.
  - AUIPC 0010111: 0010, SrcA=PC, SrcB=Imm.
  - HALT 1111111: 1101, SrcA=0, SrcB=0.
  - Any other opcode, or an illegal funct combination: Operation=4'b1111, SrcA=RD1, SrcB=RD2, illegal=1. 4'b1111 makes the ALU output 0.
- Halt FSM (states RUN, DRAIN, HALTED):
  - RUN -> DRAIN on a load of HALT.
  - DRAIN: in_ready=0.
  - DRAIN -> HALTED when out_valid && out_ready.
  - DRAIN -> RUN on flush, because the halt is cancelled.
  - HALTED: halted=1, in_ready=0, out_valid=0. Flush is ignored. Only reset exits HALTED.
- flush and in_valid in the same cycle: no load, no state change from the incoming instruction.
- flush in DRAIN takes priority over a simultaneous out_ready transfer: the state returns to RUN.
- No arithmetic is performed; all widths pass through unmodified.

Test Plan:
- Reset then R-type ADD:
  - Stimulus: Opcode=0110011, f3=000, f7=0, RD1=5, RD2=7, in_valid=1, out_ready=1.
  - Required: next cycle out_valid=1, Operation=0010, SrcA=5, SrcB=7, illegal=0.
- SRA vs SRL:
  - Stimulus: f3=101 with f7=0100000, then f3=101 with f7=0000000, back-to-back.
  - Required: Operation 0111 then 0101; in_ready stays 1 throughout.
- Backpressure:
  - Stimulus: out_ready=0 with out_valid=1 while a second instruction is presented.
  - Required: in_ready=0 and outputs hold. When out_ready=1, the second instruction loads the cycle after.
- Illegal and AUIPC:
  - Stimulus: Opcode=0001111 gives Operation=1111, illegal=1. Then AUIPC with PC=0x100, Imm=0x1000.
  - Required for AUIPC: SrcA=0x100, SrcB=0x1000, Operation=0010, illegal=0.
- Halt:
  - Stimulus: HALT accepted, out_ready=0 for 2 cycles, then 1.
  - Required: in_ready=0 from the cycle after acceptance. halted=1 the cycle after the transfer. Further in_valid is ignored until reset, which clears halted.
- Flush:
  - Stimulus: flush asserted while in DRAIN with out_valid=1.
  - Required: next cycle out_valid=0, state RUN, in_ready=1, halted=0.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus between the decoder and the ALU issue stage.
// The slave side belongs to the issue stage. The master side is the
// environment that feeds instructions and consumes ALU operands.
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [6:0]               Opcode;
    logic [2:0]               Funct3;
    logic [6:0]               Funct7;
    logic [DATA_WIDTH-1:0]    RD1;
    logic [DATA_WIDTH-1:0]    RD2;
    logic [DATA_WIDTH-1:0]    Imm;
    logic [DATA_WIDTH-1:0]    PC;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     illegal;
    logic                     halted;

    modport slave (
        input  in_valid, Opcode, Funct3, Funct7, RD1, RD2, Imm, PC, flush, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation, illegal, halted
    );

    modport master (
        output in_valid, Opcode, Funct3, Funct7, RD1, RD2, Imm, PC, flush, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation, illegal, halted
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I opcode/funct fields into an ALU operation
// code, selects the operands, and registers them behind a valid/ready
// handshake. A HALT instruction stops further issue once it has been consumed.
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_issue_stage_if.slave   bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                   state_q;
    logic                     out_valid_q;
    logic [DATA_WIDTH-1:0]    src_a_q;
    logic [DATA_WIDTH-1:0]    src_b_q;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic                     illegal_q;
    logic                     halted_q;

    logic [3:0]               code;
    logic                     legal;
    logic                     f7_zero;
    logic                     f7_alt;
    logic [DATA_WIDTH-1:0]    src_a_d;
    logic [DATA_WIDTH-1:0]    src_b_d;
    logic [OPCODE_LENGTH-1:0] op_d;
    logic                     illegal_d;
    logic                     is_halt_d;
    logic                     in_ready;
    logic                     load;

    assign f7_zero  = (bus.Funct7 == 7'b0000000);
    assign f7_alt   = (bus.Funct7 == 7'b0100000);
    assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign load     = bus.in_valid && in_ready && !bus.flush;

    // Decode the incoming fields into operation code and operand selection;
    // anything without a legal encoding falls back to code 1111 on RD1/RD2.
    always_comb begin
        code      = 4'b1111;
        legal     = 1'b1;
        src_a_d   = bus.RD1;
        src_b_d   = bus.RD2;
        is_halt_d = 1'b0;
        unique case (bus.Opcode)
            OP_R: begin
                unique case (bus.Funct3)
                    3'b000: begin code = f7_alt ? 4'b0110 : 4'b0010; legal = f7_zero || f7_alt; end
                    3'b101: begin code = f7_alt ? 4'b0111 : 4'b0101; legal = f7_zero || f7_alt; end
                    3'b111: begin code = 4'b0000; legal = f7_zero; end
                    3'b110: begin code = 4'b0001; legal = f7_zero; end
                    3'b100: begin code = 4'b0011; legal = f7_zero; end
                    3'b010: begin code = 4'b1100; legal = f7_zero; end
                    3'b001: begin code = 4'b0100; legal = f7_zero; end
                    default: legal = 1'b0;
                endcase
            end
            OP_I: begin
                src_b_d = bus.Imm;
                unique case (bus.Funct3)
                    3'b000: code = 4'b0010;
                    3'b010: code = 4'b1100;
                    3'b111: code = 4'b0000;
                    3'b110: code = 4'b0001;
                    3'b100: code = 4'b0011;
                    3'b001: begin code = 4'b0100; legal = f7_zero; end
                    3'b101: begin code = f7_alt ? 4'b0111 : 4'b0101; legal = f7_zero || f7_alt; end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
                code    = 4'b0010;
                src_b_d = bus.Imm;
            end
            OP_BRANCH: begin
                unique case (bus.Funct3)
                    3'b000: code = 4'b1000;
                    3'b001: code = 4'b1001;
                    3'b100: code = 4'b1100;
                    3'b101: code = 4'b1010;
                    default: legal = 1'b0;
                endcase
            end
            OP_JAL: begin
                code    = 4'b1101;
                src_a_d = bus.PC;
                src_b_d = bus.Imm;
            end
            OP_LUI: begin
                code    = 4'b0010;
                src_a_d = '0;
                src_b_d = bus.Imm;
            end
            OP_AUIPC: begin
                code    = 4'b0010;
                src_a_d = bus.PC;
                src_b_d = bus.Imm;
            end
            OP_HALT: begin
                code      = 4'b1101;
                src_a_d   = '0;
                src_b_d   = '0;
                is_halt_d = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            code      = 4'b1111;
            src_a_d   = bus.RD1;
            src_b_d   = bus.RD2;
            is_halt_d = 1'b0;
        end
        op_d      = OPCODE_LENGTH'(code);
        illegal_d = !legal;
    end

    // Halt FSM together with the output register; flush outranks load,
    // load outranks the consume, and HALTED only leaves on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            op_q        <= '0;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.flush) begin
                        out_valid_q <= 1'b0;
                    end else if (load) begin
                        out_valid_q <= 1'b1;
                        src_a_q     <= src_a_d;
                        src_b_q     <= src_b_d;
                        op_q        <= op_d;
                        illegal_q   <= illegal_d;
                        if (is_halt_d) begin
                            state_q <= DRAIN;
                        end
                    end else if (bus.out_ready && out_valid_q) begin
                        out_valid_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (bus.flush) begin
                        out_valid_q <= 1'b0;
                        state_q     <= RUN;
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        halted_q    <= 1'b1;
                        state_q     <= HALTED;
                    end
                end
                HALTED: begin
                    out_valid_q <= 1'b0;
                    halted_q    <= 1'b1;
                end
                default: begin
                    state_q     <= RUN;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.SrcA      = src_a_q;
    assign bus.SrcB      = src_b_q;
    assign bus.Operation = op_q;
    assign bus.illegal   = illegal_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a rule-table model predicts every cycle,
// and hand-computed literals pin the key scenarios.
module tb_alu_issue_stage;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) bus();

    alu_issue_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: decode rule table ----------------
    localparam int ANY = -1;
    localparam int A_RD1 = 0, A_PC = 1, A_ZERO = 2;
    localparam int B_RD2 = 0, B_IMM = 1, B_ZERO = 2;

    typedef struct {
        logic [6:0] opc;
        int         f3;
        int         f7;
        logic [3:0] op;
        int         asel;
        int         bsel;
    } rule_t;

    rule_t rules[$];

    function automatic void add_rule(input logic [6:0] opc, input int f3, input int f7,
                                     input logic [3:0] op, input int asel, input int bsel);
        rule_t r;
        r.opc = opc; r.f3 = f3; r.f7 = f7; r.op = op; r.asel = asel; r.bsel = bsel;
        rules.push_back(r);
    endfunction

    initial begin
        // R-type
        add_rule(7'b0110011, 0, 7'h00, 4'b0010, A_RD1, B_RD2);
        add_rule(7'b0110011, 0, 7'h20, 4'b0110, A_RD1, B_RD2);
        add_rule(7'b0110011, 7, 7'h00, 4'b0000, A_RD1, B_RD2);
        add_rule(7'b0110011, 6, 7'h00, 4'b0001, A_RD1, B_RD2);
        add_rule(7'b0110011, 4, 7'h00, 4'b0011, A_RD1, B_RD2);
        add_rule(7'b0110011, 2, 7'h00, 4'b1100, A_RD1, B_RD2);
        add_rule(7'b0110011, 1, 7'h00, 4'b0100, A_RD1, B_RD2);
        add_rule(7'b0110011, 5, 7'h00, 4'b0101, A_RD1, B_RD2);
        add_rule(7'b0110011, 5, 7'h20, 4'b0111, A_RD1, B_RD2);
        // I-ALU
        add_rule(7'b0010011, 0, ANY,   4'b0010, A_RD1, B_IMM);
        add_rule(7'b0010011, 2, ANY,   4'b1100, A_RD1, B_IMM);
        add_rule(7'b0010011, 7, ANY,   4'b0000, A_RD1, B_IMM);
        add_rule(7'b0010011, 6, ANY,   4'b0001, A_RD1, B_IMM);
        add_rule(7'b0010011, 4, ANY,   4'b0011, A_RD1, B_IMM);
        add_rule(7'b0010011, 1, 7'h00, 4'b0100, A_RD1, B_IMM);
        add_rule(7'b0010011, 5, 7'h00, 4'b0101, A_RD1, B_IMM);
        add_rule(7'b0010011, 5, 7'h20, 4'b0111, A_RD1, B_IMM);
        // memory, branches, jumps, upper immediates, halt
        add_rule(7'b0000011, ANY, ANY, 4'b0010, A_RD1, B_IMM);
        add_rule(7'b0100011, ANY, ANY, 4'b0010, A_RD1, B_IMM);
        add_rule(7'b1100011, 0, ANY,   4'b1000, A_RD1, B_RD2);
        add_rule(7'b1100011, 1, ANY,   4'b1001, A_RD1, B_RD2);
        add_rule(7'b1100011, 4, ANY,   4'b1100, A_RD1, B_RD2);
        add_rule(7'b1100011, 5, ANY,   4'b1010, A_RD1, B_RD2);
        add_rule(7'b1101111, ANY, ANY, 4'b1101, A_PC,   B_IMM);
        add_rule(7'b1100111, ANY, ANY, 4'b0010, A_RD1,  B_IMM);
        add_rule(7'b0110111, ANY, ANY, 4'b0010, A_ZERO, B_IMM);
        add_rule(7'b0010111, ANY, ANY, 4'b0010, A_PC,   B_IMM);
        add_rule(7'b1111111, ANY, ANY, 4'b1101, A_ZERO, B_ZERO);
    end

    function automatic void predict(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] rd1, input logic [31:0] rd2,
                                    input logic [31:0] imm, input logic [31:0] pc,
                                    output logic [3:0] op, output logic [31:0] a,
                                    output logic [31:0] b, output bit ill);
        bit found = 0;
        op = 4'b1111; a = rd1; b = rd2; ill = 1'b1;
        foreach (rules[i]) begin
            if (!found && rules[i].opc == opc &&
                (rules[i].f3 == ANY || rules[i].f3 == int'(f3)) &&
                (rules[i].f7 == ANY || rules[i].f7 == int'(f7))) begin
                found = 1;
                op  = rules[i].op;
                ill = 1'b0;
                a   = (rules[i].asel == A_PC) ? pc : (rules[i].asel == A_ZERO) ? 32'h0 : rd1;
                b   = (rules[i].bsel == B_IMM) ? imm : (rules[i].bsel == B_ZERO) ? 32'h0 : rd2;
            end
        end
    endfunction

    // model state: 0 = running, 1 = draining a halt, 2 = halted
    int          m_state = 0;
    bit          m_valid = 0;
    logic [31:0] m_a = 0, m_b = 0;
    logic [3:0]  m_op = 0;
    bit          m_ill = 0;
    bit          armed = 0;

    // Model advances on each rising edge from the stimulus it sees there.
    always @(posedge clk) begin : model
        logic [3:0]  p_op;
        logic [31:0] p_a, p_b;
        bit          p_ill;
        bit          p_rdy;
        if (reset) begin
            m_state = 0; m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_ill = 0;
        end else if (m_state != 2) begin
            p_rdy = (m_state == 0) && (!m_valid || bus.out_ready);
            if (bus.flush) begin
                m_valid = 0;
                if (m_state == 1) m_state = 0;
            end else if (bus.in_valid && p_rdy) begin
                predict(bus.Opcode, bus.Funct3, bus.Funct7, bus.RD1, bus.RD2, bus.Imm, bus.PC,
                        p_op, p_a, p_b, p_ill);
                m_valid = 1; m_op = p_op; m_a = p_a; m_b = p_b; m_ill = p_ill;
                if (bus.Opcode == 7'h7F) m_state = 1;
            end else if (bus.out_ready && m_valid) begin
                m_valid = 0;
                if (m_state == 1) m_state = 2;
            end
        end
        armed = 1;
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (armed) begin
            check("mdl.in_ready",  32'(bus.in_ready),  32'((m_state == 0) && (!m_valid || bus.out_ready)));
            check("mdl.out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("mdl.halted",    32'(bus.halted),    32'(m_state == 2));
            if (m_valid) begin
                check("mdl.Operation", 32'(bus.Operation), 32'(m_op));
                check("mdl.SrcA",      bus.SrcA,           m_a);
                check("mdl.SrcB",      bus.SrcB,           m_b);
                check("mdl.illegal",   32'(bus.illegal),   32'(m_ill));
                if (bus.out_ready)
                    $display("xfer t=%0t op=%b a=%h b=%h ill=%b", $time, bus.Operation, bus.SrcA, bus.SrcB, bus.illegal);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic v, input logic ordy);
        bus.Opcode = opc; bus.Funct3 = f3; bus.Funct7 = f7;
        bus.RD1 = rd1; bus.RD2 = rd2; bus.Imm = imm; bus.PC = pc;
        bus.in_valid = v; bus.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // {opcode, funct3, funct7} run back-to-back through the model
    logic [16:0] dir_vec [0:15] = '{
        {7'b1100011, 3'b000, 7'h00}, {7'b1100011, 3'b001, 7'h00},
        {7'b1100011, 3'b100, 7'h00}, {7'b1100011, 3'b101, 7'h00},
        {7'b1100011, 3'b110, 7'h00}, {7'b1101111, 3'b010, 7'h55},
        {7'b1100111, 3'b000, 7'h00}, {7'b0110111, 3'b011, 7'h12},
        {7'b0000011, 3'b010, 7'h00}, {7'b0100011, 3'b010, 7'h3F},
        {7'b0010011, 3'b000, 7'h7F}, {7'b0010011, 3'b001, 7'h20},
        {7'b0110011, 3'b000, 7'h01}, {7'b0110011, 3'b011, 7'h00},
        {7'b0110011, 3'b100, 7'h20}, {7'b0010011, 3'b101, 7'h20}
    };

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0;
        drive(7'h0, 3'h0, 7'h0, 0, 0, 0, 0, 1'b0, 1'b0);
        tick(); tick();
        check("rst.out_valid", 32'(bus.out_valid), 0);
        check("rst.SrcA", bus.SrcA, 0);
        check("rst.SrcB", bus.SrcB, 0);
        check("rst.Operation", 32'(bus.Operation), 0);
        check("rst.illegal", 32'(bus.illegal), 0);
        check("rst.halted", 32'(bus.halted), 0);
        reset = 1'b0;
        #1 check("rst.in_ready", 32'(bus.in_ready), 1);

        // ADD
        drive(7'b0110011, 3'b000, 7'h00, 5, 7, 32'h99, 32'h40, 1'b1, 1'b1);
        tick();
        check("add.out_valid", 32'(bus.out_valid), 1);
        check("add.Operation", 32'(bus.Operation), 32'b0010);
        check("add.SrcA", bus.SrcA, 5);
        check("add.SrcB", bus.SrcB, 7);
        check("add.illegal", 32'(bus.illegal), 0);

        // SRA then SRL back-to-back
        drive(7'b0110011, 3'b101, 7'h20, 32'h8000_0000, 4, 0, 0, 1'b1, 1'b1);
        #1 check("sra.in_ready", 32'(bus.in_ready), 1);
        tick();
        check("sra.Operation", 32'(bus.Operation), 32'b0111);
        check("sra.in_ready", 32'(bus.in_ready), 1);
        drive(7'b0110011, 3'b101, 7'h00, 32'h8000_0000, 4, 0, 0, 1'b1, 1'b1);
        tick();
        check("srl.Operation", 32'(bus.Operation), 32'b0101);
        check("srl.in_ready", 32'(bus.in_ready), 1);

        // Backpressure: SUB loaded, then OR held off while out_ready=0
        drive(7'b0110011, 3'b000, 7'h20, 9, 3, 0, 0, 1'b1, 1'b1);
        tick();
        drive(7'b0110011, 3'b110, 7'h00, 32'hF0, 32'h0F, 0, 0, 1'b1, 1'b0);
        #1 check("bp.in_ready", 32'(bus.in_ready), 0);
        tick();
        check("bp.hold.Operation", 32'(bus.Operation), 32'b0110);
        check("bp.hold.SrcA", bus.SrcA, 9);
        check("bp.hold.out_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        #1 check("bp.release.in_ready", 32'(bus.in_ready), 1);
        tick();
        check("bp.or.Operation", 32'(bus.Operation), 32'b0001);
        check("bp.or.SrcA", bus.SrcA, 32'hF0);
        check("bp.or.SrcB", bus.SrcB, 32'h0F);

        // Illegal opcode, then AUIPC
        drive(7'b0001111, 3'b000, 7'h00, 32'h11, 32'h22, 32'h33, 32'h44, 1'b1, 1'b1);
        tick();
        check("ill.Operation", 32'(bus.Operation), 32'b1111);
        check("ill.illegal", 32'(bus.illegal), 1);
        check("ill.SrcA", bus.SrcA, 32'h11);
        drive(7'b0010111, 3'b000, 7'h00, 32'hDEAD, 32'hBEEF, 32'h1000, 32'h100, 1'b1, 1'b1);
        tick();
        check("auipc.SrcA", bus.SrcA, 32'h100);
        check("auipc.SrcB", bus.SrcB, 32'h1000);
        check("auipc.Operation", 32'(bus.Operation), 32'b0010);
        check("auipc.illegal", 32'(bus.illegal), 0);

        // Directed table through the model
        for (int i = 0; i < 16; i++) begin
            logic [16:0] v;
            v = dir_vec[i];
            drive(v[16:10], v[9:7], v[6:0], 32'h1000_0000 + i, 32'h2000_0000 + i,
                  32'hFFFF_F000 | i, 32'h400 + 4 * i, 1'b1, 1'b1);
            tick();
            if (i == 3) check("bge.Operation", 32'(bus.Operation), 32'b1010);
            if (i == 7) begin
                check("lui.SrcA", bus.SrcA, 0);
                check("lui.SrcB", bus.SrcB, 32'hFFFF_F007);
            end
        end

        // Flush while draining a HALT
        drive(7'b1111111, 3'b000, 7'h00, 1, 2, 3, 4, 1'b1, 1'b1);
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1 check("drain.in_ready", 32'(bus.in_ready), 0);
        tick();
        check("drain.out_valid", 32'(bus.out_valid), 1);
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        check("flush.out_valid", 32'(bus.out_valid), 0);
        check("flush.in_ready", 32'(bus.in_ready), 1);
        check("flush.halted", 32'(bus.halted), 0);

        // flush with in_valid: nothing loads
        drive(7'b0110011, 3'b000, 7'h00, 5, 7, 0, 0, 1'b1, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flushin.out_valid", 32'(bus.out_valid), 0);

        // HALT runs to completion
        drive(7'b1111111, 3'b000, 7'h00, 1, 2, 3, 4, 1'b1, 1'b0);
        tick();
        check("halt.in_ready", 32'(bus.in_ready), 0);
        check("halt.Operation", 32'(bus.Operation), 32'b1101);
        check("halt.SrcA", bus.SrcA, 0);
        check("halt.SrcB", bus.SrcB, 0);
        drive(7'b0110011, 3'b000, 7'h00, 5, 7, 0, 0, 1'b1, 1'b0);
        tick(); tick();
        check("halt.wait.out_valid", 32'(bus.out_valid), 1);
        check("halt.wait.halted", 32'(bus.halted), 0);
        bus.out_ready = 1'b1;
        tick();
        check("halted.halted", 32'(bus.halted), 1);
        check("halted.out_valid", 32'(bus.out_valid), 0);
        check("halted.in_ready", 32'(bus.in_ready), 0);
        bus.flush = 1'b1;
        tick(); tick();
        bus.flush = 1'b0;
        tick();
        check("halted.sticky", 32'(bus.halted), 1);
        check("halted.ignore", 32'(bus.out_valid), 0);
        reset = 1'b1;
        tick();
        check("rst2.halted", 32'(bus.halted), 0);
        check("rst2.out_valid", 32'(bus.out_valid), 0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1 check("rst2.in_ready", 32'(bus.in_ready), 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
